vx_stream_pkt_arb: RTL and testbench

VX_STREAM_PKT_ARB -- requirements
Module: VX_stream_pkt_arb

---
 rtl/vx_stream_pkt_arb.sv | 216 +++++++++++++++++++++
 tb/tb_vx_stream_pkt_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_stream_pkt_arb.sv
// vx_stream_pkt_arb: packet-granular round-robin stream arbiter.
// Optional perf counters are built when PKT_ARB_PERF_EN is defined.
module vx_stream_pkt_arb #(
  parameter int  NUM_INPUTS = 4,
  parameter int  DATAW      = 32,
  parameter int  QUANTUM    = 1,
  parameter int  OUT_BUF    = 0,
  localparam int SELW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            valid_in,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]            last_in,
  output logic [NUM_INPUTS-1:0]            ready_in,
  output logic                             valid_out,
  output logic [DATAW-1:0]                 data_out,
  output logic                             last_out,
  input  logic                             ready_out,
  output logic [SELW-1:0]                  sel_out,
  output logic [31:0]                      perf_pkts,
  output logic [31:0]                      perf_stalls
);

  localparam int CNTW = $clog2(QUANTUM + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] owner_q, owner_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [SELW-1:0] scan_idx;
  logic [SELW-1:0] scan_cand;
  logic            scan_found;
  logic [SELW-1:0] grant_idx;
  logic            grant_vld;
  logic            sink_rdy;
  logic            beat_acc;
  logic [CNTW-1:0] cnt_base;
  logic [CNTW-1:0] cnt_inc;

  function automatic logic [SELW-1:0] wrap_idx(input int v);
    return SELW'(v % NUM_INPUTS);
  endfunction

  // find the first valid input at or after rr_ptr, cyclically
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = rr_ptr_q;
    scan_cand  = rr_ptr_q;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      scan_cand = wrap_idx(int'(rr_ptr_q) + k);
      if (!scan_found && valid_in[scan_cand]) begin
        scan_found = 1'b1;
        scan_idx   = scan_cand;
      end
    end
  end

  // grant selection, lock tracking and quantum bookkeeping
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    grant_idx = scan_idx;
    grant_vld = scan_found;
    cnt_base  = pkt_cnt_q;
    ready_in  = '0;
    unique case (state_q)
      IDLE: begin
        // a different input winning restarts the quantum
        if (scan_idx != rr_ptr_q) cnt_base = '0;
      end
      LOCKED: begin
        grant_idx = owner_q;
        grant_vld = valid_in[owner_q];
      end
      default: ;
    endcase
    beat_acc            = grant_vld & sink_rdy;
    ready_in[grant_idx] = beat_acc;
    cnt_inc             = cnt_base + CNTW'(1);
    if (beat_acc) begin
      pkt_cnt_d = cnt_base;
      if (!last_in[grant_idx]) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d = IDLE;
        if (cnt_inc == CNTW'(QUANTUM)) begin
          rr_ptr_d  = wrap_idx(int'(grant_idx) + 1);
          pkt_cnt_d = '0;
        end else begin
          rr_ptr_d  = grant_idx;
          pkt_cnt_d = cnt_inc;
        end
      end
    end
  end

  // arbitration state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  generate
    if (OUT_BUF == 0) begin : g_comb
      assign sink_rdy  = ready_out;
      assign valid_out = grant_vld;
      assign data_out  = data_in[grant_idx];
      assign last_out  = last_in[grant_idx];
      assign sel_out   = grant_idx;
    end else begin : g_skid
      logic [DATAW-1:0] sk_data_q [2];
      logic [DATAW-1:0] sk_data_d [2];
      logic [SELW-1:0]  sk_sel_q [2];
      logic [SELW-1:0]  sk_sel_d [2];
      logic [1:0]       sk_last_q, sk_last_d;
      logic             sk_wr_q, sk_wr_d;
      logic             sk_rd_q, sk_rd_d;
      logic [1:0]       sk_cnt_q, sk_cnt_d;
      logic             sk_pop;

      // ready depends only on registered fill level
      assign sink_rdy  = (sk_cnt_q != 2'd2);
      assign valid_out = (sk_cnt_q != 2'd0);
      assign data_out  = sk_data_q[sk_rd_q];
      assign last_out  = sk_last_q[sk_rd_q];
      assign sel_out   = sk_sel_q[sk_rd_q];
      assign sk_pop    = valid_out & ready_out;

      // two-entry fifo push/pop
      always_comb begin
        sk_data_d = sk_data_q;
        sk_sel_d  = sk_sel_q;
        sk_last_d = sk_last_q;
        sk_wr_d   = sk_wr_q;
        sk_rd_d   = sk_rd_q;
        if (beat_acc) begin
          sk_data_d[sk_wr_q] = data_in[grant_idx];
          sk_sel_d[sk_wr_q]  = grant_idx;
          sk_last_d[sk_wr_q] = last_in[grant_idx];
          sk_wr_d            = ~sk_wr_q;
        end
        if (sk_pop) sk_rd_d = ~sk_rd_q;
        sk_cnt_d = sk_cnt_q + {1'b0, beat_acc} - {1'b0, sk_pop};
      end

      // skid storage registers
      always_ff @(posedge clk) begin
        if (reset) begin
          sk_data_q <= '{default: '0};
          sk_sel_q  <= '{default: '0};
          sk_last_q <= '0;
          sk_wr_q   <= 1'b0;
          sk_rd_q   <= 1'b0;
          sk_cnt_q  <= '0;
        end else begin
          sk_data_q <= sk_data_d;
          sk_sel_q  <= sk_sel_d;
          sk_last_q <= sk_last_d;
          sk_wr_q   <= sk_wr_d;
          sk_rd_q   <= sk_rd_d;
          sk_cnt_q  <= sk_cnt_d;
        end
      end
    end
  endgenerate

`ifdef PKT_ARB_PERF_EN
  logic [31:0] perf_pkts_q, perf_pkts_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // count delivered packets and back-pressured cycles
  always_comb begin
    perf_pkts_d   = perf_pkts_q;
    perf_stalls_d = perf_stalls_q;
    if (valid_out & ready_out & last_out) perf_pkts_d = perf_pkts_q + 32'd1;
    if (valid_out & ~ready_out) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  // perf counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_pkts_q   <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_pkts_q   <= perf_pkts_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_pkts   = perf_pkts_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_pkts   = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vx_stream_pkt_arb.sv
// tb_vx_stream_pkt_arb: vectors + scoreboard bench for vx_stream_pkt_arb.
// Unit a: defaults; unit b: QUANTUM=2, OUT_BUF=1.
module tb_vx_stream_pkt_arb;

`ifdef PKT_ARB_PERF_EN
  localparam int EXP_PKTS   = 5;
  localparam int EXP_STALLS = 7;
`else
  localparam int EXP_PKTS   = 0;
  localparam int EXP_STALLS = 0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  s;
  } exp_t;

  typedef struct {
    logic [3:0] v;
    logic       ro;
    logic       evo;
    logic [3:0] eri;
    logic [1:0] esel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0]       vin [2];
  logic [3:0]       lin [2];
  logic [3:0][31:0] din [2];
  logic             rout [2];

  logic [3:0]  a_rin, b_rin;
  logic        a_vout, b_vout, a_lout, b_lout;
  logic [31:0] a_dout, b_dout;
  logic [1:0]  a_sel, b_sel;
  logic [31:0] a_pp, a_ps, b_pp, b_ps;

  logic [3:0]  rin [2];
  logic        vout [2];
  logic        lout [2];
  logic [31:0] dout [2];
  logic [1:0]  sel [2];

  assign rin[0]  = a_rin;
  assign rin[1]  = b_rin;
  assign vout[0] = a_vout;
  assign vout[1] = b_vout;
  assign lout[0] = a_lout;
  assign lout[1] = b_lout;
  assign dout[0] = a_dout;
  assign dout[1] = b_dout;
  assign sel[0]  = a_sel;
  assign sel[1]  = b_sel;

  vx_stream_pkt_arb #(
    .NUM_INPUTS(4), .DATAW(32), .QUANTUM(1), .OUT_BUF(0)
  ) u_a (
    .clk(clk), .reset(rst),
    .valid_in(vin[0]), .data_in(din[0]), .last_in(lin[0]),
    .ready_in(a_rin),
    .valid_out(a_vout), .data_out(a_dout), .last_out(a_lout),
    .ready_out(rout[0]), .sel_out(a_sel),
    .perf_pkts(a_pp), .perf_stalls(a_ps)
  );

  vx_stream_pkt_arb #(
    .NUM_INPUTS(4), .DATAW(32), .QUANTUM(2), .OUT_BUF(1)
  ) u_b (
    .clk(clk), .reset(rst),
    .valid_in(vin[1]), .data_in(din[1]), .last_in(lin[1]),
    .ready_in(b_rin),
    .valid_out(b_vout), .data_out(b_dout), .last_out(b_lout),
    .ready_out(rout[1]), .sel_out(b_sel),
    .perf_pkts(b_pp), .perf_stalls(b_ps)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t smem [4][16];
  int    slen [4];
  int    spos [4];
  exp_t  sb [$];
  int    gap_src, gap_after, gap_len, gap_cnt;
  vec_t  tv [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bd(int s, int p, int b);
    return {8'hD0, 8'(s), 8'(p), 8'(b)};
  endfunction

  function automatic void clear_src();
    for (int i = 0; i < 4; i++) begin
      slen[i] = 0;
      spos[i] = 0;
    end
    sb.delete();
    gap_src   = -1;
    gap_after = 0;
    gap_len   = 0;
    gap_cnt   = 0;
  endfunction

  function automatic void load(int s, int np, int nb);
    for (int p = 0; p < np; p++)
      for (int b = 0; b < nb; b++) begin
        smem[s][slen[s]] = '{d: bd(s, p, b), l: (b == nb - 1)};
        slen[s]++;
      end
  endfunction

  function automatic void expect_pkt(int s, int p, int nb);
    for (int b = 0; b < nb; b++)
      sb.push_back('{d: bd(s, p, b), l: (b == nb - 1), s: 2'(s)});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      vin[u]  = '0;
      lin[u]  = '0;
      din[u]  = '0;
      rout[u] = 1'b1;
    end
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run(input int u, input int max_cyc, input bit tog);
    int         cyc;
    logic [3:0] gm;
    logic [3:0] acc;
    exp_t       e;
    cyc = 0;
    while (sb.size() != 0 && cyc < max_cyc) begin
      gm = '0;
      for (int i = 0; i < 4; i++) begin
        gm[i] = (i == gap_src) && (spos[i] >= gap_after) &&
                (gap_cnt < gap_len);
        vin[u][i] = (spos[i] < slen[i]) && !gm[i];
        din[u][i] = (spos[i] < slen[i]) ? smem[i][spos[i]].d : '0;
        lin[u][i] = (spos[i] < slen[i]) ? smem[i][spos[i]].l : 1'b0;
      end
      rout[u] = tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      chk("rdy_onehot0", 32'($onehot0(rin[u])), 32'd1);
      if (gm != 0) begin
        chk("gap_vout", 32'(vout[u]), 32'd0);
        chk("gap_rdy", 32'(rin[u]), 32'd0);
        gap_cnt++;
      end
      if (u == 0 && rin[0] != 0)
        chk("rdy_grant", 32'(rin[0]), 32'(4'b0001 << sel[0]));
      if (vout[u] && rout[u]) begin
        e = sb.pop_front();
        chk("data", dout[u], e.d);
        chk("sel", 32'(sel[u]), 32'(e.s));
        chk("last", 32'(lout[u]), 32'(e.l));
      end
      acc = vin[u] & rin[u];
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (acc[i]) spos[i]++;
      cyc++;
    end
    chk("drain", sb.size(), 32'd0);
    vin[u]  = '0;
    lin[u]  = '0;
    rout[u] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0};
    tv[1] = '{4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1};
    tv[2] = '{4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3};
    tv[3] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0};
    tv[4] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    tv[5] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
    tv[6] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0};
    tv[7] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2};
    tv[8] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3};

    do_reset();
    @(negedge clk);
    chk("rst_a_vout", 32'(a_vout), 32'd0);
    chk("rst_a_rdy", 32'(a_rin), 32'd0);
    chk("rst_a_sel", 32'(a_sel), 32'd0);
    chk("rst_a_pkts", a_pp, 32'd0);
    chk("rst_a_stalls", a_ps, 32'd0);
    chk("rst_b_vout", 32'(b_vout), 32'd0);
    chk("rst_b_sel", 32'(b_sel), 32'd0);
    chk("rst_b_rdy", 32'(b_rin), 32'd0);
    @(posedge clk);
    #1;

    for (int t = 0; t < 9; t++) begin
      vin[0]  = tv[t].v;
      lin[0]  = 4'hF;
      rout[0] = tv[t].ro;
      for (int i = 0; i < 4; i++) din[0][i] = 32'hA0 + i;
      @(negedge clk);
      chk("tv_vout", 32'(a_vout), 32'(tv[t].evo));
      chk("tv_rdy", 32'(a_rin), 32'(tv[t].eri));
      if (tv[t].evo) begin
        chk("tv_sel", 32'(a_sel), 32'(tv[t].esel));
        chk("tv_data", a_dout, 32'hA0 + 32'(tv[t].esel));
        chk("tv_last", 32'(a_lout), 32'd1);
      end
      @(posedge clk);
      #1;
    end

    do_reset();
    for (int i = 0; i < 4; i++) load(i, 1, 3);
    for (int i = 0; i < 4; i++) expect_pkt(i, 0, 3);
    run(0, 100, 1'b0);

    do_reset();
    load(1, 1, 3);
    load(2, 1, 2);
    gap_src   = 1;
    gap_after = 1;
    gap_len   = 4;
    expect_pkt(1, 0, 3);
    expect_pkt(2, 0, 2);
    run(0, 100, 1'b0);
    chk("gap_cycles", 32'(gap_cnt), 32'd4);

    do_reset();
    vin[0] = 4'b0010;
    lin[0] = 4'b0010;
    @(negedge clk);
    chk("r36_pre_sel", 32'(a_sel), 32'd1);
    @(posedge clk);
    #1;
    vin[0] = 4'b0100;
    lin[0] = 4'b0000;
    @(negedge clk);
    chk("r36_lock_sel", 32'(a_sel), 32'd2);
    chk("r36_lock_rdy", 32'(a_rin), 32'b0100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    vin[0] = '0;
    lin[0] = '0;
    @(negedge clk);
    chk("r36_vout", 32'(a_vout), 32'd0);
    chk("r36_rdy", 32'(a_rin), 32'd0);
    @(posedge clk);
    #1;
    vin[0] = 4'b1110;
    lin[0] = 4'b1110;
    @(negedge clk);
    chk("r36_fresh_sel", 32'(a_sel), 32'd1);
    chk("r36_fresh_rdy", 32'(a_rin), 32'b0010);
    @(posedge clk);
    #1;

    do_reset();
    vin[0]  = 4'b0001;
    lin[0]  = 4'b0001;
    rout[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rout[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vin[0] = '0;
    @(negedge clk);
    chk("perf_pkts", a_pp, 32'(EXP_PKTS));
    chk("perf_stalls", a_ps, 32'(EXP_STALLS));
    @(posedge clk);
    #1;

    do_reset();
    vin[1]    = 4'b0001;
    lin[1]    = 4'b0001;
    din[1][0] = 32'h5A5A_0001;
    rout[1]   = 1'b0;
    @(negedge clk);
    chk("lat_vout0", 32'(b_vout), 32'd0);
    chk("lat_rdy_indep", 32'(b_rin), 32'b0001);
    @(posedge clk);
    #1;
    vin[1]  = '0;
    rout[1] = 1'b1;
    @(negedge clk);
    chk("lat_vout1", 32'(b_vout), 32'd1);
    chk("lat_data", b_dout, 32'h5A5A_0001);
    chk("lat_sel", 32'(b_sel), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_empty", 32'(b_vout), 32'd0);
    @(posedge clk);
    #1;

    do_reset();
    load(0, 6, 1);
    load(3, 6, 1);
    for (int k = 0; k < 3; k++) begin
      expect_pkt(0, 2 * k, 1);
      expect_pkt(0, 2 * k + 1, 1);
      expect_pkt(3, 2 * k, 1);
      expect_pkt(3, 2 * k + 1, 1);
    end
    run(1, 100, 1'b0);

    do_reset();
    for (int i = 0; i < 4; i++) load(i, 1, 3);
    for (int i = 0; i < 4; i++) expect_pkt(i, 0, 3);
    run(1, 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
